// File: rtl/plab4_net_router_domain_tdm_sched.sv
// Time-division scheduler that gives two security domains alternating,
// fixed-length ownership of one input port's output-request path. The
// schedule depends only on time and reset, so one domain's traffic cannot
// change when the other domain is served.
module plab4_net_router_domain_tdm_sched #(
    parameter int unsigned p_slot_cycles = 4,
    parameter int unsigned p_dead_cycles = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] reqs_d1,
    input  logic [2:0] reqs_d2,
    input  logic [2:0] grants,
    output logic [2:0] reqs,
    output logic [2:0] grants_d1,
    output logic [2:0] grants_d2,
    output logic       in_rdy_d1,
    output logic       in_rdy_d2,
    output logic       domain,
    output logic       slot_start
);

    localparam int unsigned c_cnt_max =
        (p_slot_cycles > p_dead_cycles) ? p_slot_cycles : p_dead_cycles;
    localparam int unsigned c_cnt_nbits = $clog2(c_cnt_max + 1);

    localparam logic [c_cnt_nbits-1:0] c_slot_last = c_cnt_nbits'(p_slot_cycles - 1);
    // Only used when dead cycles exist; guarded to avoid an underflowed reload.
    localparam logic [c_cnt_nbits-1:0] c_dead_last =
        (p_dead_cycles == 0) ? '0 : c_cnt_nbits'(p_dead_cycles - 1);

    typedef enum logic [1:0] {StOwnD1, StDead12, StOwnD2, StDead21} state_e;

    state_e                 state_q, state_d;
    logic [c_cnt_nbits-1:0] cnt_q, cnt_d;
    logic                   own_d1, own_d2;

    // Next-state: count down within a phase, advance to the next phase at zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (cnt_q != '0) begin
            cnt_d = cnt_q - c_cnt_nbits'(1);
        end else begin
            unique case (state_q)
                StOwnD1: begin
                    if (p_dead_cycles == 0) begin
                        state_d = StOwnD2;
                        cnt_d   = c_slot_last;
                    end else begin
                        state_d = StDead12;
                        cnt_d   = c_dead_last;
                    end
                end
                StOwnD2: begin
                    if (p_dead_cycles == 0) begin
                        state_d = StOwnD1;
                        cnt_d   = c_slot_last;
                    end else begin
                        state_d = StDead21;
                        cnt_d   = c_dead_last;
                    end
                end
                StDead12: begin
                    state_d = StOwnD2;
                    cnt_d   = c_slot_last;
                end
                StDead21: begin
                    state_d = StOwnD1;
                    cnt_d   = c_slot_last;
                end
                default: begin
                    state_d = StOwnD1;
                    cnt_d   = c_slot_last;
                end
            endcase
        end
    end

    // Schedule state; reset restarts a full d1 slot with no carry-over.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StOwnD1;
            cnt_q   <= c_slot_last;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request/grant steering: only the slot owner is connected; reset blanks all.
    always_comb begin
        own_d1     = (state_q == StOwnD1) && !reset;
        own_d2     = (state_q == StOwnD2) && !reset;
        reqs       = own_d1 ? reqs_d1 : (own_d2 ? reqs_d2 : 3'b000);
        grants_d1  = own_d1 ? grants : 3'b000;
        grants_d2  = own_d2 ? grants : 3'b000;
        in_rdy_d1  = |(reqs_d1 & grants_d1);
        in_rdy_d2  = |(reqs_d2 & grants_d2);
        // Dead states keep reporting the domain that just owned the port.
        domain     = (state_q == StOwnD2) || (state_q == StDead21);
        slot_start = ((state_q == StOwnD1) || (state_q == StOwnD2)) && (cnt_q == c_slot_last);
    end

endmodule

// File: tb/tb_plab4_net_router_domain_tdm_sched.sv
// Directed bench for the TDM domain scheduler: default schedule, no lending,
// non-interference, 1-cycle/no-dead schedule, mid-slot reset, idle-owner grants.
module tb_plab4_net_router_domain_tdm_sched;

    logic clk;
    logic reset;
    logic rst_c;

    // Instance A: default parameters, main directed traffic.
    logic [2:0] rd1_a, rd2_a, g_a, reqs_a, g1_a, g2_a;
    logic       rdy1_a, rdy2_a, dom_a, ss_a;
    // Instance B: default parameters, d2 driven randomly (non-interference).
    logic [2:0] rd1_b, rd2_b, g_b, reqs_b, g1_b, g2_b;
    logic       rdy1_b, rdy2_b, dom_b, ss_b;
    // Instance C: one-cycle slots, no dead cycles.
    logic [2:0] rd1_c, rd2_c, g_c, reqs_c, g1_c, g2_c;
    logic       rdy1_c, rdy2_c, dom_c, ss_c;

    int cyc;
    int cyc_c;
    int errors;
    int checks;

    plab4_net_router_domain_tdm_sched dut_a (
        .clk(clk), .reset(reset), .reqs_d1(rd1_a), .reqs_d2(rd2_a), .grants(g_a),
        .reqs(reqs_a), .grants_d1(g1_a), .grants_d2(g2_a), .in_rdy_d1(rdy1_a),
        .in_rdy_d2(rdy2_a), .domain(dom_a), .slot_start(ss_a)
    );

    plab4_net_router_domain_tdm_sched dut_b (
        .clk(clk), .reset(reset), .reqs_d1(rd1_b), .reqs_d2(rd2_b), .grants(g_b),
        .reqs(reqs_b), .grants_d1(g1_b), .grants_d2(g2_b), .in_rdy_d1(rdy1_b),
        .in_rdy_d2(rdy2_b), .domain(dom_b), .slot_start(ss_b)
    );

    plab4_net_router_domain_tdm_sched #(
        .p_slot_cycles(1),
        .p_dead_cycles(0)
    ) dut_c (
        .clk(clk), .reset(rst_c), .reqs_d1(rd1_c), .reqs_d2(rd2_c), .grants(g_c),
        .reqs(reqs_c), .grants_d1(g1_c), .grants_d2(g2_c), .in_rdy_d1(rdy1_c),
        .in_rdy_d2(rdy2_c), .domain(dom_c), .slot_start(ss_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0b expected=%0b", tag, cyc, obs, exp_v);
        end
    endtask

    // Expected behaviour of A/B from the 10-cycle schedule:
    // phase 0-3 own d1, 4 dead, 5-8 own d2, 9 dead.
    task automatic check_ab();
        int   ph;
        logic own1, own2;
        ph   = cyc % 10;
        own1 = (ph < 4);
        own2 = (ph >= 5) && (ph <= 8);
        chk("a_reqs", reqs_a, own1 ? rd1_a : (own2 ? rd2_a : 3'b000));
        chk("a_grants_d1", g1_a, own1 ? g_a : 3'b000);
        chk("a_grants_d2", g2_a, own2 ? g_a : 3'b000);
        chk("a_in_rdy_d1", {2'b00, rdy1_a}, {2'b00, own1 && ((rd1_a & g_a) != 3'b000)});
        chk("a_in_rdy_d2", {2'b00, rdy2_a}, {2'b00, own2 && ((rd2_a & g_a) != 3'b000)});
        chk("a_domain", {2'b00, dom_a}, {2'b00, ph >= 5});
        chk("a_slot_start", {2'b00, ss_a}, {2'b00, (ph == 0) || (ph == 5)});
        // B's d1 trace must follow the schedule whatever d2 does.
        chk("b_in_rdy_d1", {2'b00, rdy1_b}, {2'b00, own1});
        chk("b_grants_d1", g1_b, own1 ? 3'b111 : 3'b000);
    endtask

    task automatic check_c();
        logic odd;
        odd = (cyc_c % 2) == 1;
        chk("c_domain", {2'b00, dom_c}, {2'b00, odd});
        chk("c_slot_start", {2'b00, ss_c}, 3'b001);
        chk("c_reqs", reqs_c, odd ? 3'b010 : 3'b001);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        cyc++;
        cyc_c++;
        rd2_b = 3'($urandom_range(0, 7));
    endtask

    task automatic settle_check();
        #1;
        check_ab();
        check_c();
    endtask

    task automatic check_in_reset();
        chk("rst_reqs", reqs_a, 3'b000);
        chk("rst_grants_d1", g1_a, 3'b000);
        chk("rst_grants_d2", g2_a, 3'b000);
        chk("rst_in_rdy", {1'b0, rdy1_a, rdy2_a}, 3'b000);
        chk("rst_domain", {2'b00, dom_a}, 3'b000);
        chk("rst_slot_start", {2'b00, ss_a}, 3'b001);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        cyc    = 0;
        cyc_c  = 0;
        reset  = 1'b1;
        rst_c  = 1'b1;
        rd1_a  = 3'b001; rd2_a = 3'b010; g_a = 3'b011;
        rd1_b  = 3'b001; rd2_b = 3'b000; g_b = 3'b111;
        rd1_c  = 3'b001; rd2_c = 3'b010; g_c = 3'b011;

        // Reset state with requests pending: everything blanked.
        repeat (2) @(posedge clk);
        #1;
        check_in_reset();

        // Test 1 (+3, +4): default schedule over two full periods.
        reset = 1'b0;
        rst_c = 1'b0;
        settle_check();
        repeat (19) begin
            advance();
            settle_check();
        end

        // Test 2: only d2 requests; nothing forwarded outside its slot.
        advance();
        rd1_a = 3'b000; rd2_a = 3'b100; g_a = 3'b100;
        settle_check();
        repeat (9) begin
            advance();
            settle_check();
        end

        // Test 6: grants while the owner is idle pass through, no in_rdy.
        advance();
        rd1_a = 3'b000; rd2_a = 3'b000; g_a = 3'b111;
        settle_check();
        repeat (9) begin
            advance();
            settle_check();
        end

        // Test 5: reset in phase 6 (inside the d2 slot).
        advance();
        rd1_a = 3'b001; rd2_a = 3'b010; g_a = 3'b111;
        settle_check();
        for (int k = 0; k < 20 && (cyc % 10) != 6; k++) begin
            advance();
            settle_check();
        end
        chk("pre_rst_phase", {2'b00, dom_a}, 3'b001);
        reset = 1'b1;
        #1;
        check_in_reset();
        advance();
        #1;
        check_in_reset();
        check_c();
        reset = 1'b0;
        cyc   = 0;
        settle_check();
        repeat (10) begin
            advance();
            settle_check();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
